// File: rtl/led_show_if.sv
// Control and LED-drive bundle between board-level control and the light-show driver.
// Level-held signals only (no valid/ready): inputs are sampled every clk, outputs are valid every clk.
interface led_show_if #(
  parameter int N_LED = 16,
  parameter int PWM_W = 4
);
  logic             en;
  logic [1:0]       mode;
  logic [1:0]       speed;
  logic [PWM_W-1:0] bright;
  logic [N_LED-1:0] led;
  logic             frame;
  logic [1:0]       dbg_mode;

  modport master (output en, mode, speed, bright, input led, frame, dbg_mode);
  modport slave  (input en, mode, speed, bright, output led, frame, dbg_mode);
endinterface

// File: rtl/led_show_drv.sv
// Parametrised LED light-show driver: outward/inward shift, bounce scanner and bar fill,
// with a speed-selectable tick prescaler, PWM brightness and a one-clk frame pulse.
module led_show_drv #(
  parameter int N_LED  = 16,
  parameter int TICK_W = 23,
  parameter int BURST  = 3,
  parameter int PERIOD = 16,
  parameter int PWM_W  = 4
) (
  input  logic       clk,
  input  logic       rst,
  led_show_if.slave  bus
);
  localparam int H     = N_LED / 2;
  localparam int POS_W = $clog2(N_LED);
  localparam int LVL_W = $clog2(N_LED + 1);
  localparam int CS_W  = $clog2(PERIOD);
  localparam logic [CS_W-1:0]  BURST_C  = CS_W'(BURST);
  localparam logic [CS_W-1:0]  CS_LAST  = CS_W'(PERIOD - 1);
  localparam logic [POS_W-1:0] POS_TOP  = POS_W'(N_LED - 1);
  localparam logic [LVL_W-1:0] LVL_TOP  = LVL_W'(N_LED);

  typedef enum logic [1:0] {M_SHIFT_OUT, M_SHIFT_IN, M_BOUNCE, M_FILL} mode_e;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

  logic [TICK_W-1:0] cnt_t, cnt_t_n, tick_mask;
  mode_e             mode_q, mode_q_n, mode_in;
  logic [H-1:0]      lo_h, lo_h_n, hi_h, hi_h_n;
  logic [POS_W-1:0]  pos, pos_n;
  dir_e              dir, dir_n;
  logic [LVL_W-1:0]  level, level_n;
  logic [CS_W-1:0]   cnt_s, cnt_s_n;
  logic [PWM_W-1:0]  pwm_cnt, pwm_n;
  logic              frame_pend, frame_pend_n, frame_q, frame_q_n;
  logic [N_LED-1:0]  pattern, led_q, led_n;
  logic              tck, s_in;

  assign mode_in   = mode_e'(bus.mode);
  // Faster speeds shorten the run of low ones that must match, halving the tick period per step.
  assign tick_mask = {TICK_W{1'b1}} >> bus.speed;
  assign tck       = &(cnt_t | ~tick_mask);
  assign s_in      = (cnt_s < BURST_C);

  always_comb begin
    pattern = '0;
    case (mode_q)
      M_SHIFT_OUT: pattern = {hi_h, lo_h};
      M_SHIFT_IN:  pattern = {lo_h, hi_h};
      M_BOUNCE:    pattern[pos] = 1'b1;
      M_FILL:      for (int i = 0; i < N_LED; i++) pattern[i] = (LVL_W'(i) < level);
      default:     pattern = '0;
    endcase
  end

  always_comb begin
    cnt_t_n      = cnt_t + 1'b1;
    mode_q_n     = mode_q;
    lo_h_n       = lo_h;
    hi_h_n       = hi_h;
    pos_n        = pos;
    dir_n        = dir;
    level_n      = level;
    cnt_s_n      = cnt_s;
    frame_pend_n = 1'b0;
    pwm_n        = pwm_cnt + 1'b1;
    led_n        = pattern & {N_LED{pwm_cnt <= bus.bright}};
    frame_q_n    = frame_pend;
    // A mode change restarts the new pattern from its cleared state and swallows any tick.
    if (mode_in != mode_q) begin
      mode_q_n = mode_in;
      cnt_t_n  = '0;
      lo_h_n   = '0;
      hi_h_n   = '0;
      pos_n    = '0;
      dir_n    = DIR_UP;
      level_n  = '0;
      cnt_s_n  = '0;
    end else if (tck) begin
      case (mode_q)
        M_SHIFT_OUT, M_SHIFT_IN: begin
          hi_h_n       = {hi_h[H-2:0], s_in};
          lo_h_n       = {s_in, lo_h[H-1:1]};
          cnt_s_n      = cnt_s + 1'b1;
          frame_pend_n = (cnt_s == CS_LAST);
        end
        M_BOUNCE: begin
          if (dir == DIR_UP) begin
            pos_n = pos + 1'b1;
            if (pos_n == POS_TOP) dir_n = DIR_DOWN;
          end else begin
            pos_n = pos - 1'b1;
            if (pos_n == '0) begin
              dir_n        = DIR_UP;
              frame_pend_n = 1'b1;
            end
          end
        end
        default: begin
          if (level == LVL_TOP) begin
            level_n      = '0;
            frame_pend_n = 1'b1;
          end else begin
            level_n = level + 1'b1;
          end
        end
      endcase
    end
  end

  // en low is a full clear, just like rst, so the show always restarts from scratch.
  always_ff @(posedge clk) begin
    if (rst || !bus.en) begin
      cnt_t      <= '0;
      mode_q     <= M_SHIFT_OUT;
      lo_h       <= '0;
      hi_h       <= '0;
      pos        <= '0;
      dir        <= DIR_UP;
      level      <= '0;
      cnt_s      <= '0;
      pwm_cnt    <= '0;
      frame_pend <= 1'b0;
      led_q      <= '0;
      frame_q    <= 1'b0;
    end else begin
      cnt_t      <= cnt_t_n;
      mode_q     <= mode_q_n;
      lo_h       <= lo_h_n;
      hi_h       <= hi_h_n;
      pos        <= pos_n;
      dir        <= dir_n;
      level      <= level_n;
      cnt_s      <= cnt_s_n;
      pwm_cnt    <= pwm_n;
      frame_pend <= frame_pend_n;
      led_q      <= led_n;
      frame_q    <= frame_q_n;
    end
  end

  assign bus.led      = bus.en ? led_q : '0;
  assign bus.frame    = bus.en & frame_q;
  assign bus.dbg_mode = mode_q;
endmodule
